serial_adder_tmr: RTL

- Bit-serial adder built around the existing single-bit fulladder cell, which it instantiates as one stage.
- The block owns the sequencing that the combinational cell lacks: operand shift registers, the bit counter, the carry feedback register and the start/done handshake.
- The carry register is triplicated and majority-voted, in line with the lab's fault-tolerance theme.
- It sits directly upstream of the fulladder cell: it feeds it one bit pair per cycle and consumes its s/cout outputs.

---
 rtl/serial_adder_tmr_if.sv | 25 ++
 rtl/serial_adder_tmr.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_tmr_if.sv
// Handshake and operand/result bundle for the bit-serial TMR adder.
// The master side requests an addition; the slave side (the adder) reports the result.
interface serial_adder_tmr_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             carry_err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, carry_err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, carry_err
  );
endinterface

// File: rtl/serial_adder_tmr.sv
// Bit-serial adder: one fulladder stage, with operand shifters, a bit counter and a
// triplicated, majority-voted carry feedback register that is rewritten every cycle.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_tmr #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_tmr_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             cv_s, fa_s_s, fa_co_s;

  assign cv_s = maj3(c0_q, c1_q, c2_q);

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (cv_s),
    .s    (fa_s_s),
    .cout (fa_co_s)
  );

  // Next-state and datapath update for the IDLE/RUN sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    c0_d     = c0_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c0_d    = bus.cin;
          c1_d    = bus.cin;
          c2_d    = bus.cin;
          cnt_d   = {CNT_W{1'b0}};
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_s_s;
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        // Reloading every copy from the voted result scrubs a single upset each cycle.
        c0_d                = fa_co_s;
        c1_d                = fa_co_s;
        c2_d                = fa_co_s;
        cnt_d               = cnt_q + CNT_W'(1);
        if ((c0_q != c1_q) || (c1_q != c2_q)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sum_sh_d;
          cout_d  = fa_co_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      sum_sh_q <= {WIDTH{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      c0_q     <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.carry_err = err_q;
endmodule
